// File: rtl/bomb_sprite_fetch.sv
// -----------------------------------------------------------------------------
// bomb_sprite_fetch
//
// Purpose:
//   Reads one row of the 16x16 RGB332 bomb sprite from a 128x16 ROM into a
//   16-pixel line buffer during hblank. During active video it produces the
//   sprite colour for each presented pixel column one cycle later. The ROM
//   holds two pixels per word and eight words per row, in row-major order.
//   The ROM registers its address internally, so q is valid one cycle after
//   the address is presented.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-low reset
//   line_start     one-cycle pulse at hblank start; starts a fetch for line_y
//   line_y         scanline about to be displayed
//   sprite_x/y     sprite top-left corner in screen coordinates
//   sprite_en      sprite visible
//   pixel_x        current active pixel column
//   pixel_en       pixel_x is valid this cycle
//   rom_address    ROM word address
//   rom_chipselect ROM chipselect, high only while words are being fetched
//   rom_clken      ROM clock enable, tied high
//   rom_readdata   ROM q
//   pix_color      sprite colour for the pixel_x of the previous cycle
//   pix_valid      pix_color is an opaque sprite pixel
//   busy           a line fetch is in progress
// -----------------------------------------------------------------------------
module bomb_sprite_fetch #(
    parameter int         SPR_W       = 16,
    parameter int         SPR_H       = 16,
    parameter logic [7:0] TRANSPARENT = 8'hE3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [9:0]  line_y,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic        sprite_en,
    input  logic [9:0]  pixel_x,
    input  logic        pixel_en,
    output logic [6:0]  rom_address,
    output logic        rom_chipselect,
    output logic        rom_clken,
    input  logic [15:0] rom_readdata,
    output logic [7:0]  pix_color,
    output logic        pix_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // Copies of the geometry taken at line_start. The rest of the line uses
    // only these copies, so the inputs may change after the pulse.
    logic [9:0]  r_line_y;
    logic [9:0]  r_sprite_x;
    logic [9:0]  r_sprite_y;
    logic        r_sprite_en;

    logic [2:0]  r_wc;        // word counter within the row
    logic        r_row_hit;   // line buffer holds the row for this scanline
    logic        r_wr_valid;  // a word was issued last cycle; its data is on q now
    logic [2:0]  r_wr_k;      // which word was issued last cycle
    logic [7:0]  r_buf [SPR_W];

    logic [7:0]  r_pix_color;
    logic        r_pix_valid;

    // The operands are zero-extended to 11 bits. A negative difference then
    // has bit 10 set. So it compares as a large unsigned value and cannot
    // alias into the 0..15 range.
    logic [10:0] w_row_diff;
    logic        w_row_in;
    logic [10:0] w_col;
    logic        w_hit;
    logic [7:0]  w_buf_pix;

    assign w_row_diff = {1'b0, r_line_y} - {1'b0, r_sprite_y};
    assign w_row_in   = r_sprite_en && (w_row_diff < 11'(SPR_H));
    assign w_col      = {1'b0, pixel_x} - {1'b0, r_sprite_x};
    assign w_hit      = pixel_en && r_row_hit && (w_col < 11'(SPR_W));
    assign w_buf_pix  = r_buf[w_col[3:0]];

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    // NOTE: the default is assigned first, so no path leaves w_next_state
    // unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = S_IDLE;
            S_CHECK: w_next_state = w_row_in ? S_FETCH : S_IDLE;
            S_FETCH: w_next_state = (r_wc == 3'd7) ? S_DRAIN : S_FETCH;
            S_DRAIN: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        // A new line always wins and restarts the fetch, even one in progress.
        if (line_start) begin
            w_next_state = S_CHECK;
        end
    end

    // -------------------------------------------------------------------------
    // Fetch control and pixel path
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_line_y    <= '0;
            r_sprite_x  <= '0;
            r_sprite_y  <= '0;
            r_sprite_en <= 1'b0;
            r_wc        <= '0;
            r_row_hit   <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_wr_k      <= '0;
            r_pix_color <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            // The ROM returns data one cycle after the address is presented,
            // so remember which word is in flight.
            r_wr_valid <= (r_state == S_FETCH);
            r_wr_k     <= r_wc;

            if (line_start) begin
                r_line_y    <= line_y;
                r_sprite_x  <= sprite_x;
                r_sprite_y  <= sprite_y;
                r_sprite_en <= sprite_en;
                r_row_hit   <= 1'b0;
                r_wc        <= '0;
            end else begin
                case (r_state)
                    S_CHECK: r_wc      <= '0;
                    S_FETCH: r_wc      <= r_wc + 3'd1;
                    S_DRAIN: r_row_hit <= 1'b1;   // word 7 lands this cycle
                    default: ;
                endcase
            end

            r_pix_color <= w_hit ? w_buf_pix : 8'h00;
            r_pix_valid <= w_hit && (w_buf_pix != TRANSPARENT);
        end
    end

    // -------------------------------------------------------------------------
    // Line buffer
    // -------------------------------------------------------------------------
    // NOTE: the buffer has no reset. Its contents are only read while
    // r_row_hit is set, and a complete row has been written by then.
    always_ff @(posedge clk) begin
        if (r_wr_valid) begin
            r_buf[{r_wr_k, 1'b0}] <= rom_readdata[15:8];
            r_buf[{r_wr_k, 1'b1}] <= rom_readdata[7:0];
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rom_address    = (r_state == S_FETCH) ? {w_row_diff[3:0], r_wc} : 7'd0;
    assign rom_chipselect = (r_state == S_FETCH);
    assign rom_clken      = 1'b1;
    assign busy           = (r_state != S_IDLE);
    assign pix_color      = r_pix_color;
    assign pix_valid      = r_pix_valid;

endmodule

// File: tb/tb_bomb_sprite_fetch.sv
module tb_bomb_sprite_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        line_start;
    logic [9:0]  line_y;
    logic [9:0]  sprite_x;
    logic [9:0]  sprite_y;
    logic        sprite_en;
    logic [9:0]  pixel_x;
    logic        pixel_en;
    logic [6:0]  rom_address;
    logic        rom_chipselect;
    logic        rom_clken;
    logic [15:0] rom_readdata;
    logic [7:0]  pix_color;
    logic        pix_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Behavioural ROM: the address is registered and q is unregistered.
    logic [15:0] rom [128];
    logic [6:0]  rom_addr_q = 7'd0;
    always @(posedge clk) if (rom_clken) rom_addr_q <= rom_address;
    assign rom_readdata = rom[rom_addr_q];

    // Reference model state: which sprite row is loaded and where it sits.
    bit m_loaded = 0;
    int m_row    = 0;
    int m_sx     = 0;

    always #5 clk = ~clk;

    bomb_sprite_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .line_start     (line_start),
        .line_y         (line_y),
        .sprite_x       (sprite_x),
        .sprite_y       (sprite_y),
        .sprite_en      (sprite_en),
        .pixel_x        (pixel_x),
        .pixel_en       (pixel_en),
        .rom_address    (rom_address),
        .rom_chipselect (rom_chipselect),
        .rom_clken      (rom_clken),
        .rom_readdata   (rom_readdata),
        .pix_color      (pix_color),
        .pix_valid      (pix_valid),
        .busy           (busy)
    );

    // Returns {valid, colour} expected one cycle after (x, en) is presented.
    // Pixel c of row r is in word r*8 + c/2: the high byte for even c and
    // the low byte for odd c.
    function automatic logic [8:0] model_pix(input int x, input bit en);
        int          col;
        logic [15:0] word;
        logic [7:0]  c;
        col = x - m_sx;
        if (!en || !m_loaded || col < 0 || col > 15) return 9'h000;
        word = rom[m_row * 8 + col / 2];
        c = (col % 2 == 0) ? word[15:8] : word[7:0];
        return {c != 8'hE3, c};
    endfunction

    // All drives happen 1 time unit after a rising edge. Samples are taken at
    // the same point, before anything is changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pixel_step(input int x, input bit en);
        pixel_x  = 10'(x);
        pixel_en = en;
        step();
    endtask

    // Pulse line_start and let the fetch finish. The model records the
    // row that the specification says should then be loaded.
    task automatic load_line(input int sy, input int ly, input int sx, input bit en);
        line_start = 1'b1;
        sprite_y   = 10'(sy);
        line_y     = 10'(ly);
        sprite_x   = 10'(sx);
        sprite_en  = en;
        pixel_en   = 1'b0;
        step();
        line_start = 1'b0;
        repeat (12) step();
        m_row    = ly - sy;
        m_loaded = en && (m_row >= 0) && (m_row < 16);
        m_sx     = sx;
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 128; i++) begin
            logic [7:0] hi, lo;
            hi = ($urandom % 4 == 0) ? 8'hE3 : 8'($urandom);
            lo = ($urandom % 4 == 0) ? 8'hE3 : 8'($urandom);
            rom[i] = {hi, lo};
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        if (busy !== 1'b0 || rom_chipselect !== 1'b0 || rom_address !== 7'd0 ||
            pix_valid !== 1'b0 || pix_color !== 8'h00) begin
            $display("FAIL reset_state: busy=%b cs=%b addr=%h valid=%b color=%h, required all zero",
                     busy, rom_chipselect, rom_address, pix_valid, pix_color);
            errors++;
        end
        checks++;
        if (rom_clken !== 1'b1) begin
            $display("FAIL rom_clken: got %b required 1", rom_clken);
            errors++;
        end
        checks++;
        reset = 1'b1;
        step();
        m_loaded = 0;
    endtask

    // Fetches row 3 (sprite_y=100, line_y=103) with pixel_x held at sprite_x
    // and checks the cycle-by-cycle timing, counted from the pulse cycle.
    task automatic test_fetch_timing();
        int cs_count = 0;
        rom[8'h18] = 16'h1CE3;
        line_start = 1'b1;
        line_y = 10'd103; sprite_y = 10'd100; sprite_x = 10'd200; sprite_en = 1'b1;
        pixel_x = 10'd200; pixel_en = 1'b1;
        step();
        line_start = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            bit exp_cs;
            exp_cs = (n >= 2) && (n <= 9);
            if (rom_chipselect === 1'b1) cs_count++;
            if (rom_chipselect !== exp_cs) begin
                $display("FAIL fetch_cs cycle %0d: got %b required %b", n, rom_chipselect, exp_cs);
                errors++;
            end
            checks++;
            if (exp_cs && rom_address !== 7'(8'h18 + n - 2)) begin
                $display("FAIL fetch_addr cycle %0d: got %h required %h", n, rom_address, 7'(8'h18 + n - 2));
                errors++;
            end
            if (exp_cs) checks++;
            if (busy !== (n <= 10)) begin
                $display("FAIL fetch_busy cycle %0d: got %b required %b", n, busy, n <= 10);
                errors++;
            end
            checks++;
            // The row becomes usable at cycle 11, so it shows on the output at cycle 12.
            if (pix_valid !== (n >= 12)) begin
                $display("FAIL fetch_rowhit cycle %0d: pix_valid got %b required %b", n, pix_valid, n >= 12);
                errors++;
            end
            checks++;
            step();
        end
        if (cs_count != 8) begin
            $display("FAIL fetch_cs_count: got %0d required 8", cs_count);
            errors++;
        end
        checks++;
        m_loaded = 1; m_row = 3; m_sx = 200;
        pixel_en = 1'b0;
        step();
    endtask

    task automatic test_pixels();
        int xs [4] = '{200, 201, 199, 216};
        logic [8:0] req [4] = '{9'h11C, 9'h0E3, 9'h000, 9'h000};
        for (int i = 0; i < 4; i++) begin
            pixel_step(xs[i], 1'b1);
            if ({pix_valid, pix_color} !== req[i]) begin
                $display("FAIL pixel_x=%0d: got valid=%b color=%h required valid=%b color=%h",
                         xs[i], pix_valid, pix_color, req[i][8], req[i][7:0]);
                errors++;
            end
            checks++;
        end
        // The remaining columns of row 3 are checked against the ROM model.
        for (int x = 198; x <= 218; x++) begin
            logic [8:0] e;
            e = model_pix(x, 1'b1);
            pixel_step(x, 1'b1);
            if ({pix_valid, pix_color} !== e) begin
                $display("FAIL row3_sweep x=%0d: got %b/%h required %b/%h", x, pix_valid, pix_color, e[8], e[7:0]);
                errors++;
            end
            checks++;
        end
        pixel_en = 1'b0;
    endtask

    task automatic test_row_miss();
        int lys [2] = '{99, 116};
        for (int t = 0; t < 2; t++) begin
            int cs_seen = 0;
            line_start = 1'b1;
            line_y = 10'(lys[t]); sprite_y = 10'd100; sprite_x = 10'd200; sprite_en = 1'b1;
            step();
            line_start = 1'b0;
            for (int n = 0; n < 14; n++) begin
                if (rom_chipselect !== 1'b0) cs_seen++;
                step();
            end
            if (cs_seen != 0) begin
                $display("FAIL row_miss_cs line_y=%0d: chipselect high %0d cycles, required 0", lys[t], cs_seen);
                errors++;
            end
            checks++;
            m_loaded = 0;
            for (int x = 0; x < 640; x++) begin
                pixel_step(x, 1'b1);
                if (pix_valid !== 1'b0 || pix_color !== 8'h00) begin
                    $display("FAIL row_miss_pix line_y=%0d x=%0d: got %b/%h required 0/00", lys[t], x, pix_valid, pix_color);
                    errors++;
                end
                checks++;
            end
            pixel_en = 1'b0;
        end
    endtask

    task automatic test_clip();
        load_line(50, 57, 630, 1'b1);
        for (int x = 0; x < 640; x++) begin
            logic [8:0] e;
            e = model_pix(x, 1'b1);
            pixel_step(x, 1'b1);
            if ({pix_valid, pix_color} !== e) begin
                $display("FAIL clip x=%0d: got %b/%h required %b/%h", x, pix_valid, pix_color, e[8], e[7:0]);
                errors++;
            end
            checks++;
        end
        pixel_en = 1'b0;
    endtask

    task automatic test_abort();
        line_start = 1'b1;
        line_y = 10'd103; sprite_y = 10'd100; sprite_x = 10'd300; sprite_en = 1'b1;
        pixel_en = 1'b0;
        step();
        line_start = 1'b0;
        repeat (5) step();   // now at cycle 6, the fifth cycle of FETCH
        line_start = 1'b1;
        line_y = 10'd101;
        step();
        line_start = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            bit exp_cs;
            exp_cs = (n >= 2) && (n <= 9);
            if (rom_chipselect !== exp_cs || (exp_cs && rom_address !== 7'(8 + n - 2))) begin
                $display("FAIL abort_addr cycle %0d: cs=%b addr=%h required cs=%b addr=%h",
                         n, rom_chipselect, rom_address, exp_cs, 7'(8 + n - 2));
                errors++;
            end
            checks++;
            if (busy !== (n <= 10)) begin
                $display("FAIL abort_busy cycle %0d: got %b required %b", n, busy, n <= 10);
                errors++;
            end
            checks++;
            // The row is usable from cycle 11 after the second pulse.
            pixel_x  = 10'd300;
            pixel_en = (n == 10) || (n == 11);
            step();
            if (n == 10 || n == 11) begin
                if (pix_color !== ((n == 11) ? rom[8][15:8] : 8'h00)) begin
                    $display("FAIL abort_rowhit cycle %0d: color got %h required %h",
                             n, pix_color, (n == 11) ? rom[8][15:8] : 8'h00);
                    errors++;
                end
                checks++;
            end
        end
        m_loaded = 1; m_row = 1; m_sx = 300;
        for (int x = 298; x <= 318; x++) begin
            logic [8:0] e;
            e = model_pix(x, 1'b1);
            pixel_step(x, 1'b1);
            if ({pix_valid, pix_color} !== e) begin
                $display("FAIL abort_row1 x=%0d: got %b/%h required %b/%h", x, pix_valid, pix_color, e[8], e[7:0]);
                errors++;
            end
            checks++;
        end
        pixel_en = 1'b0;
    endtask

    task automatic test_reset_midfetch();
        int cs_seen = 0;
        line_start = 1'b1;
        line_y = 10'd110; sprite_y = 10'd100; sprite_x = 10'd100; sprite_en = 1'b1;
        step();
        line_start = 1'b0;
        repeat (4) step();   // cycle 5: FETCH is in progress
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        if (busy !== 1'b0 || rom_chipselect !== 1'b0 || pix_valid !== 1'b0) begin
            $display("FAIL reset_midfetch: busy=%b cs=%b valid=%b required 0/0/0", busy, rom_chipselect, pix_valid);
            errors++;
        end
        checks++;
        m_loaded = 0;
        for (int n = 0; n < 14; n++) begin
            pixel_step(100 + n, 1'b1);
            if (rom_chipselect !== 1'b0) cs_seen++;
            if (pix_valid !== 1'b0) cs_seen++;
        end
        if (cs_seen != 0) begin
            $display("FAIL reset_midfetch_after: %0d cycles of chipselect/pix_valid activity, required 0", cs_seen);
            errors++;
        end
        checks++;
        pixel_en = 1'b0;
    endtask

    task automatic test_random_lines();
        for (int it = 0; it < 10; it++) begin
            int sy, ly, sx;
            bit en;
            sy = $urandom_range(0, 460);
            ly = sy + $urandom_range(0, 40) - 8;
            if (ly < 0) ly = 0;
            sx = $urandom_range(0, 639);
            en = ($urandom % 4) != 0;
            load_line(sy, ly, sx, en);
            for (int k = 0; k < 40; k++) begin
                int x;
                bit pe;
                logic [8:0] e;
                x = sx + $urandom_range(0, 24) - 4;
                if (x < 0) x = 0;
                if (x > 639) x = 639;
                pe = ($urandom % 4) != 0;
                e = model_pix(x, pe);
                pixel_step(x, pe);
                if ({pix_valid, pix_color} !== e) begin
                    $display("FAIL random it=%0d x=%0d en=%b: got %b/%h required %b/%h",
                             it, x, pe, pix_valid, pix_color, e[8], e[7:0]);
                    errors++;
                end
                checks++;
            end
            pixel_en = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b0; line_start = 1'b0; line_y = '0; sprite_x = '0; sprite_y = '0;
        sprite_en = 1'b0; pixel_x = '0; pixel_en = 1'b0;
        fill_rom();
        test_reset();
        test_fetch_timing();
        test_pixels();
        test_row_miss();
        test_clip();
        test_abort();
        test_reset_midfetch();
        test_random_lines();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
